// File: rtl/counter_pkg.sv
// Shared constants for the loadable down counter and its decrementer datapath.
package counter_pkg;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
  localparam int CNT_ZERO  = 0;
endpackage

// File: rtl/and_gate.sv
// Two-input AND primitive for the gate-level arithmetic chains.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/decrementer_4bit.sv
// Ripple half-subtractor chain with a fixed borrow-in of 1: s = a - 1.
// b[i] is the borrow out of bit i, i.e. high iff a[i:0] is all zeros.
module decrementer_4bit
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] b
);
  logic [WIDTH-1:0] a_n;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      inv_gate u_inv (.a(a[i]), .y(a_n[i]));
      if (i == 0) begin : g_lsb
        // Borrow-in is 1, so both difference and borrow reduce to ~a[0].
        assign s[0] = a_n[0];
        assign b[0] = a_n[0];
      end else begin : g_upper
        xor_gate u_xor (.a(a[i]),   .b(b[i-1]), .y(s[i]));
        and_gate u_and (.a(a_n[i]), .b(b[i-1]), .y(b[i]));
      end
    end
  endgenerate
endmodule

// File: rtl/inv_gate.sv
// Single-bit inverter primitive for the gate-level arithmetic chains.
module inv_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// File: rtl/xor_gate.sv
// Two-input XOR primitive for the gate-level arithmetic chains.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/down_counter_4bit.sv
// Loadable down counter with borrow cascade and registered underflow pulse.
// Define DOWN_COUNTER_SATURATE_EN to hold at zero instead of wrapping (bout tied low).
module down_counter_4bit
  import counter_pkg::*;
#(
  parameter int               WIDTH   = CNT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] b,
  output logic             bout,
  output logic             zero,
  output logic             uf
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             uf_q, uf_d;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] dec_b;

  decrementer_4bit #(.WIDTH(WIDTH)) u_dec (
    .a (q_q),
    .s (dec_s),
    .b (dec_b)
  );

  // Borrow out of the top bit is exactly "q is zero", so it doubles as the underflow condition.
  always_comb begin
    q_d  = q_q;
    uf_d = 1'b0;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      uf_d = dec_b[WIDTH-1];
`ifdef DOWN_COUNTER_SATURATE_EN
      q_d  = dec_b[WIDTH-1] ? q_q : dec_s;
`else
      q_d  = dec_s;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q  <= RST_VAL;
      uf_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      uf_q <= uf_d;
    end
  end

  assign q    = q_q;
  assign uf   = uf_q;
  assign b    = dec_b;
  assign zero = (q_q == WIDTH'(CNT_ZERO));
`ifdef DOWN_COUNTER_SATURATE_EN
  assign bout = 1'b0;
`else
  assign bout = en & dec_b[WIDTH-1];
`endif
endmodule
